// File: rtl/sparc_ram_responder.sv
// rtl/sparc_ram_responder.sv - MOV/MOC memory-side responder, 512-byte big-endian RAM
// Optional alignment fault reporting: define SPARC_RAM_ALIGN_CHECK_EN.
module sparc_ram_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        Type,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MOC,
  output logic              Err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [3:0] CNT_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  reg [7:0] Mem [0:DEPTH-1];

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_rw;
  logic [1:0]        r_type;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [31:0]       r_dout;

  logic              w_start;
  logic              w_access;
  logic              w_rw;
  logic              w_misalign;
  logic [1:0]        w_type;
  logic [31:0]       w_din;
  logic [31:0]       w_rdata;
  logic [ADDR_W-1:0] w_a0;
  logic [ADDR_W-1:0] w_a1;
  logic [ADDR_W-1:0] w_a2;
  logic [ADDR_W-1:0] w_a3;

  // With zero wait states the access happens at E0, so use the live inputs.
  assign w_start  = (r_state == S_IDLE) && MOV;
  assign w_access = (w_start && (WAIT_STATES == 0)) ||
                    ((r_state == S_WAIT) && (r_cnt == 4'd0));
  assign w_rw     = w_start ? RW      : r_rw;
  assign w_type   = w_start ? Type    : r_type;
  assign w_a0     = w_start ? Address : r_addr;
  assign w_din    = w_start ? DataIn  : r_data;
  assign w_a1     = w_a0 + ADDR_W'(1);
  assign w_a2     = w_a0 + ADDR_W'(2);
  assign w_a3     = w_a0 + ADDR_W'(3);

  always_comb begin
    w_rdata = 32'h0;
    case (w_type)
      2'b00:   w_rdata = {24'h0, Mem[w_a0]};
      2'b01:   w_rdata = {16'h0, Mem[w_a0], Mem[w_a1]};
      default: w_rdata = {Mem[w_a0], Mem[w_a1], Mem[w_a2], Mem[w_a3]};
    endcase
  end

`ifdef SPARC_RAM_ALIGN_CHECK_EN
  logic r_err;

  always_comb begin
    w_misalign = 1'b0;
    case (w_type)
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = w_a0[0];
      default: w_misalign = |w_a0[1:0];
    endcase
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_err <= 1'b0;
    end else if (w_access) begin
      r_err <= w_misalign;
    end
  end

  assign Err = MOC && r_err;
`else
  assign w_misalign = 1'b0;
  assign Err        = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rw    <= 1'b0;
      r_type  <= 2'b00;
      r_addr  <= '0;
      r_data  <= 32'h0;
      r_dout  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (MOV) begin
            r_rw   <= RW;
            r_type <= Type;
            r_addr <= Address;
            r_data <= DataIn;
            if (WAIT_STATES == 0) begin
              r_state <= S_DONE;
            end else begin
              r_cnt   <= CNT_LOAD;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!MOV) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_access && w_rw && !w_misalign) begin
        r_dout <= w_rdata;
      end
    end
  end

  // RAM has no reset so a backdoor preload survives Clr.
  always @(posedge Clk) begin
    if (w_access && !w_rw && !w_misalign && !Clr) begin
      case (w_type)
        2'b00: Mem[w_a0] <= w_din[7:0];
        2'b01: begin
          Mem[w_a0] <= w_din[15:8];
          Mem[w_a1] <= w_din[7:0];
        end
        default: begin
          Mem[w_a0] <= w_din[31:24];
          Mem[w_a1] <= w_din[23:16];
          Mem[w_a2] <= w_din[15:8];
          Mem[w_a3] <= w_din[7:0];
        end
      endcase
    end
  end

  assign MOC     = (r_state == S_DONE);
  assign DataOut = r_dout;

endmodule

// File: tb/tb_sparc_ram_responder.sv
// tb/tb_sparc_ram_responder.sv - scoreboard bench for sparc_ram_responder
// Alignment cases follow SPARC_RAM_ALIGN_CHECK_EN when defined.
module tb_sparc_ram_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic        MOV = 1'b0;
  logic        RW = 1'b0;
  logic [1:0]  Type = 2'b00;
  logic [8:0]  Address = 9'h0;
  logic [31:0] DataIn = 32'h0;
  logic [31:0] DataOut;
  logic        MOC;
  logic        Err;

  logic        MOV0 = 1'b0;
  logic        RW0 = 1'b0;
  logic [1:0]  Type0 = 2'b00;
  logic [8:0]  Address0 = 9'h0;
  logic [31:0] DataIn0 = 32'h0;
  logic [31:0] DataOut0;
  logic        MOC0;
  logic        Err0;

  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  logic prev_moc = 1'b0;

  sparc_ram_responder #(.ADDR_W(9), .WAIT_STATES(2)) dut (
    .Clk(Clk), .Clr(Clr), .MOV(MOV), .RW(RW), .Type(Type), .Address(Address),
    .DataIn(DataIn), .DataOut(DataOut), .MOC(MOC), .Err(Err)
  );

  sparc_ram_responder #(.ADDR_W(9), .WAIT_STATES(0)) dut0 (
    .Clk(Clk), .Clr(Clr), .MOV(MOV0), .RW(RW0), .Type(Type0), .Address(Address0),
    .DataIn(DataIn0), .DataOut(DataOut0), .MOC(MOC0), .Err(Err0)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (MOC && !prev_moc) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_moc: got MOC=1 expected no response");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_dataout", DataOut, e.data);
        chk("sb_err", {31'h0, Err}, {31'h0, e.err});
      end
    end
    prev_moc = MOC;
  end

  task automatic req(input logic rw, input logic [1:0] ty, input logic [8:0] a,
                     input logic [31:0] d, input logic [31:0] exp_do, input logic exp_err);
    int lat;
    exp_t e;
    e.data = exp_do;
    e.err  = exp_err;
    sb_q.push_back(e);
    lat = -1;
    @(negedge Clk);
    MOV = 1'b1; RW = rw; Type = ty; Address = a; DataIn = d;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (i == 0) begin
        RW = ~rw; Type = ~ty; Address = ~a; DataIn = ~d;
      end
      if (MOC) begin
        lat = i;
        break;
      end
    end
    chk("moc_latency", 32'(lat), 32'd2);
    @(posedge Clk);
    @(negedge Clk);
    chk("moc_hold", {31'h0, MOC}, 32'd1);
    MOV = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    chk("moc_release", {31'h0, MOC}, 32'd0);
  endtask

  initial begin
    int   highs;
    int   lat;
    exp_t e;
    dut.Mem[0] = 8'h12; dut.Mem[1] = 8'h34; dut.Mem[2] = 8'h56; dut.Mem[3] = 8'h78;
    dut.Mem[4] = 8'h11; dut.Mem[5] = 8'h22; dut.Mem[6] = 8'h33; dut.Mem[7] = 8'h44;
    dut.Mem[9'h012] = 8'h5A;
    dut0.Mem[9'h010] = 8'hAB; dut0.Mem[9'h011] = 8'hCD;
    dut0.Mem[9'h012] = 8'h5A; dut0.Mem[9'h013] = 8'h3C;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Clr = 1'b0;
    @(negedge Clk);
    chk("rst_moc", {31'h0, MOC}, 32'd0);
    chk("rst_dataout", DataOut, 32'h0);
    chk("rst_err", {31'h0, Err}, 32'd0);
    chk("rst_moc_ws0", {31'h0, MOC0}, 32'd0);

    req(1'b1, 2'b10, 9'h000, 32'h0, 32'h12345678, 1'b0);

    req(1'b0, 2'b01, 9'h010, 32'hFFFFABCD, 32'h12345678, 1'b0);
    req(1'b1, 2'b00, 9'h010, 32'h0, 32'h000000AB, 1'b0);
    req(1'b1, 2'b00, 9'h011, 32'h0, 32'h000000CD, 1'b0);
    chk("hw_write_neighbour", {24'h0, dut.Mem[9'h012]}, 32'h5A);
    req(1'b1, 2'b01, 9'h010, 32'h0, 32'h0000ABCD, 1'b0);

    @(negedge Clk);
    MOV = 1'b1; RW = 1'b0; Type = 2'b10; Address = 9'h004; DataIn = 32'hA5A5A5A5;
    @(posedge Clk);
    @(posedge Clk);
    #1 Clr = 1'b1;
    #1;
    chk("clr_wait_moc", {31'h0, MOC}, 32'd0);
    chk("clr_wait_dataout", DataOut, 32'h0);
    @(negedge Clk);
    MOV = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Clr = 1'b0;
    chk("clr_no_write", {dut.Mem[4], dut.Mem[5], dut.Mem[6], dut.Mem[7]}, 32'h11223344);
    req(1'b1, 2'b10, 9'h004, 32'h0, 32'h11223344, 1'b0);

    e.data = 32'h00000012;
    e.err  = 1'b0;
    sb_q.push_back(e);
    @(negedge Clk);
    MOV = 1'b1; RW = 1'b1; Type = 2'b00; Address = 9'h000;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (MOC) begin
        lat = i;
        break;
      end
    end
    chk("done_clr_latency", 32'(lat), 32'd2);
    #2 Clr = 1'b1;
    #1;
    chk("clr_done_moc", {31'h0, MOC}, 32'd0);
    chk("clr_done_dataout", DataOut, 32'h0);
    @(negedge Clk);
    MOV = 1'b0;
    Clr = 1'b0;

    @(negedge Clk);
    MOV0 = 1'b1; RW0 = 1'b1; Type0 = 2'b10; Address0 = 9'h010;
    @(posedge Clk);
    #1;
    chk("ws0_moc_at_e0", {31'h0, MOC0}, 32'd1);
    chk("ws0_dataout", DataOut0, 32'hABCD5A3C);
    @(negedge Clk);
    MOV0 = 1'b0;
    @(posedge Clk);
    #1;
    chk("ws0_moc_release", {31'h0, MOC0}, 32'd0);

    e.data = 32'h000000CD;
    e.err  = 1'b0;
    sb_q.push_back(e);
    @(negedge Clk);
    MOV = 1'b1; RW = 1'b1; Type = 2'b00; Address = 9'h011;
    @(posedge Clk);
    @(negedge Clk);
    MOV = 1'b0;
    highs = 0;
    repeat (6) begin
      @(negedge Clk);
      if (MOC) highs++;
    end
    chk("mov_drop_pulse", 32'(highs), 32'd1);

`ifdef SPARC_RAM_ALIGN_CHECK_EN
    req(1'b0, 2'b10, 9'h002, 32'hCAFEF00D, 32'h000000CD, 1'b1);
    chk("misalign_no_write", {dut.Mem[2], dut.Mem[3], dut.Mem[4], dut.Mem[5]}, 32'h56781122);
    req(1'b1, 2'b10, 9'h000, 32'h0, 32'h12345678, 1'b0);
`else
    req(1'b0, 2'b10, 9'h1FF, 32'hDEADBEEF, 32'h000000CD, 1'b0);
    chk("wrap_write", {dut.Mem[511], dut.Mem[0], dut.Mem[1], dut.Mem[2]}, 32'hDEADBEEF);
    req(1'b1, 2'b10, 9'h1FF, 32'h0, 32'hDEADBEEF, 1'b0);
`endif

    repeat (2) @(negedge Clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sparc_ram_responder.md
Name: sparc_ram_responder

Overview:
- Memory-side responder for the SPARC MPU's MOV/MOC memory handshake.
- The control unit raises MOV with address, R/W and access type. This block performs the access into a 512-byte, big-endian, byte-addressed RAM.
- It then raises MOC after a programmable number of wait states.
- It is the other end of the MOV/R_W/TYPE interface driven by the control unit's signal encoder. It replaces ad-hoc RAM models in MPU simulations.

Parameters:
- ADDR_W, 9: byte address width; RAM depth is 2**ADDR_W bytes.
- WAIT_STATES, 2: number of clock edges from MOV sampling to MOC assertion, range 0..15.

Ports:
- Clk  in  1  system clock; rising edge active.
- Clr  in  1  asynchronous, active-high reset.
- MOV  in  1  memory operation valid, from the control unit.
- RW  in  1  0 = write, 1 = read.
- Type  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- Address  in  ADDR_W  byte address of the most significant byte.
- DataIn  in  32  write data, right-justified.
- DataOut  out  32  read data, right-justified, zero-extended.
- MOC  out  1  memory operation complete.
- Err  out  1  access fault; only meaningful with the optional feature.

Behaviour:
Reset:
- Clr is asynchronous and active-high.
- Clr forces state IDLE, MOC=0, DataOut=32'h0, Err=0 and the wait counter to 0.
- RAM contents are NOT cleared, so a preload survives Clr.

States: IDLE, WAIT, DONE.

IDLE:
- MOC=0.
- On a rising edge with MOV=1, latch Address, RW, Type and DataIn into request registers. Call this edge E0.
- If WAIT_STATES=0, perform the access at E0 and go to DONE.
- Otherwise load counter=WAIT_STATES-1 and go to WAIT.

WAIT:
- While counter != 0, decrement each edge.
- At the edge where counter==0, perform the access and go to DONE.
- Net timing: MOC rises at edge E0+WAIT_STATES; with the default, 2 cycles after E0.

Access at the DONE-entry edge:
- Read: DataOut is assigned at the same edge MOC rises.
  - Byte: {24'b0, m[a]}.
  - Halfword: {16'b0, m[a], m[a+1]}.
  - Word: {m[a], m[a+1], m[a+2], m[a+3]}.
- Write:
  - Byte: m[a]=DataIn[7:0].
  - Halfword: m[a]=DataIn[15:8], m[a+1]=DataIn[7:0].
  - Word: m[a..a+3]=DataIn[31:24] .. DataIn[7:0].
  - DataOut holds its previous value on writes.
- Address arithmetic a+k is modulo 2**ADDR_W; accesses wrap from 511 to 0.

DONE:
- MOC=1; DataOut stays stable.
- Remain in DONE while MOV=1. On an edge with MOV=0, go to IDLE and drive MOC=0.
- A new request needs MOV to be low for at least one edge (full 4-phase handshake).

Changes to inputs after E0:
- Changes to Address, RW, Type or DataIn after E0 are ignored, because the request is latched.
- If MOV drops during WAIT, the access still completes. DONE is entered and MOC is high for exactly one cycle, then the block returns to IDLE.

Reset mid-operation:
- Clr during WAIT aborts with no RAM write.
- Clr during DONE clears MOC immediately, asynchronously.

Backdoor preload:
- The RAM array is a plain reg array named Mem, so benches can preload it hierarchically.

Optional Feature:
- Macro: SPARC_RAM_ALIGN_CHECK_EN.
- Defined:
  - Halfword access with Address[0]=1 is misaligned.
  - Word or reserved access with Address[1:0]!=0 is misaligned.
  - A misaligned request follows the normal timing, but RAM is not written and DataOut is not updated.
  - Err=1 together with MOC=1 in DONE; Err clears with MOC.
- Undefined:
  - No alignment check; unaligned accesses use the wrap rules above.
  - Err is tied to 0.

Test Plan:
1. Preload Mem[0..3]=8'h12,8'h34,8'h56,8'h78; MOV=1, RW=1, Type=10, Address=0 -> MOC rises exactly 2 edges after E0, DataOut=32'h12345678, MOC stays high until MOV=0.
2. Write Type=01, Address=9'h010, DataIn=32'hFFFFABCD; then read byte Address 9'h010 and 9'h011 -> DataOut=32'h000000AB, then 32'h000000CD, and Mem[9'h012] is unchanged.
3. Word write 32'hDEADBEEF at Address=511, feature off -> Mem[511]=DE, Mem[0]=AD, Mem[1]=BE, Mem[2]=EF; word read at 511 returns 32'hDEADBEEF.
4. Assert Clr one cycle after E0 of a word write to Address 4 -> MOC=0 and DataOut=0 immediately, Mem[4..7] unchanged, next request is served normally.
5. WAIT_STATES=0 instance: MOV high at E0 -> MOC=1 at E0. MOV dropped during WAIT on default instance -> MOC high for exactly one cycle.
6. With SPARC_RAM_ALIGN_CHECK_EN: word write at Address=2 -> Err=1 and MOC=1 at E0+2, Mem[2..5] unchanged. Aligned word read at 0 -> Err=0.
